// File: rtl/mult_arbiter.sv
// Two-requester round-robin front end for a shift-add multiplier datapath.
// Optional RUN watchdog enabled with `define MULT_ARB_TIMEOUT_EN (limit set by TIMEOUT).
module mult_arbiter #(
    parameter int DW      = 8,
    parameter int TIMEOUT = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_req0,
    input  logic            i_req1,
    input  logic [DW-1:0]   i_a0,
    input  logic [DW-1:0]   i_b0,
    input  logic [DW-1:0]   i_a1,
    input  logic [DW-1:0]   i_b1,
    output logic            o_gnt0,
    output logic            o_gnt1,
    output logic            o_done0,
    output logic            o_done1,
    output logic [2*DW-1:0] o_result,
    output logic            o_err,
    output logic            o_busy,
    output logic            o_clean,
    output logic            o_load,
    output logic [DW-1:0]   o_mltnd,
    output logic [DW-1:0]   o_mlter,
    input  logic            i_mltd_done,
    input  logic            i_mltr_done,
    input  logic [2*DW-1:0] i_product,
    output logic [2:0]      dbg_state
);
    // Handshake: a request is a level sampled only in IDLE; the grant stays high
    // from CLEAN through RESP and the matching done pulses for one cycle in RESP.
    typedef enum logic [2:0] {IDLE, CLEAN, LOAD, RUN, CAPTURE, RESP} state_t;

    state_t state;
    logic   last;       // requester served most recently
    logic   win;
    logic   sticky_d;
    logic   sticky_r;
    logic   both_done;
    logic   timed_out;

    // Single request wins outright; on a tie the one not served last wins.
    assign win       = (i_req0 && i_req1) ? ~last : i_req1;
    assign both_done = (sticky_d | i_mltd_done) & (sticky_r | i_mltr_done);
    assign dbg_state = state;

`ifdef MULT_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] run_cnt;
    assign timed_out = !both_done && (run_cnt == CW'(TIMEOUT - 1));
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT > 0);
    assign timed_out      = 1'b0;
    assign o_err          = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= IDLE;
            last     <= 1'b1;
            o_gnt0   <= 1'b0;
            o_gnt1   <= 1'b0;
            o_done0  <= 1'b0;
            o_done1  <= 1'b0;
            o_result <= '0;
            o_busy   <= 1'b0;
            o_clean  <= 1'b0;
            o_load   <= 1'b0;
            o_mltnd  <= '0;
            o_mlter  <= '0;
            sticky_d <= 1'b0;
            sticky_r <= 1'b0;
`ifdef MULT_ARB_TIMEOUT_EN
            run_cnt  <= '0;
            o_err    <= 1'b0;
`endif
        end else begin
            o_clean <= 1'b0;
            o_load  <= 1'b0;
            o_done0 <= 1'b0;
            o_done1 <= 1'b0;
`ifdef MULT_ARB_TIMEOUT_EN
            o_err   <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (i_req0 || i_req1) begin
                        state   <= CLEAN;
                        o_busy  <= 1'b1;
                        o_clean <= 1'b1;
                        o_gnt0  <= ~win;
                        o_gnt1  <= win;
                        o_mltnd <= win ? i_a1 : i_a0;
                        o_mlter <= win ? i_b1 : i_b0;
                    end
                end
                CLEAN: begin
                    state  <= LOAD;
                    o_load <= 1'b1;
                end
                LOAD: begin
                    state    <= RUN;
                    sticky_d <= 1'b0;
                    sticky_r <= 1'b0;
`ifdef MULT_ARB_TIMEOUT_EN
                    run_cnt  <= '0;
`endif
                end
                RUN: begin
                    sticky_d <= sticky_d | i_mltd_done;
                    sticky_r <= sticky_r | i_mltr_done;
`ifdef MULT_ARB_TIMEOUT_EN
                    run_cnt  <= run_cnt + 1'b1;
`endif
                    if (both_done) begin
                        state <= CAPTURE;
                    end else if (timed_out) begin
                        // Watchdog abort: report a zero product flagged as an error.
                        state    <= RESP;
                        o_result <= '0;
                        o_done0  <= o_gnt0;
                        o_done1  <= o_gnt1;
                        o_mltnd  <= '0;
                        o_mlter  <= '0;
`ifdef MULT_ARB_TIMEOUT_EN
                        o_err    <= 1'b1;
`endif
                    end
                end
                CAPTURE: begin
                    state    <= RESP;
                    o_result <= i_product;
                    o_done0  <= o_gnt0;
                    o_done1  <= o_gnt1;
                    o_mltnd  <= '0;
                    o_mlter  <= '0;
                end
                RESP: begin
                    state  <= IDLE;
                    last   <= o_gnt1;
                    o_gnt0 <= 1'b0;
                    o_gnt1 <= 1'b0;
                    o_busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter: vector table, hand-written corner
// sequences and randomized transactions checked against a round-robin model.
module tb_mult_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [7:0]  a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic        gnt0, gnt1, done0, done1, err, busy, clean, load;
    logic [15:0] result;
    logic [7:0]  mltnd, mlter;
    logic        mltd_done = 1'b0, mltr_done = 1'b0;
    logic [15:0] product = '0;
    logic [2:0]  state;

    int n_checks = 0;
    int n_pass   = 0;
    int model_last = 1;

    mult_arbiter #(.DW(8), .TIMEOUT(32)) dut (
        .i_clk(clk), .i_rst(rst), .i_req0(req0), .i_req1(req1),
        .i_a0(a0), .i_b0(b0), .i_a1(a1), .i_b1(b1),
        .o_gnt0(gnt0), .o_gnt1(gnt1), .o_done0(done0), .o_done1(done1),
        .o_result(result), .o_err(err), .o_busy(busy), .o_clean(clean),
        .o_load(load), .o_mltnd(mltnd), .o_mlter(mlter),
        .i_mltd_done(mltd_done), .i_mltr_done(mltr_done), .i_product(product),
        .dbg_state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         r0, r1;
        logic [7:0] a0, b0, a1, b1;
        int         d_at, r_at;
        bit         hold;
        int         exp_win;
        logic [15:0] exp_res;
        int         exp_done;
    } vec_t;

    vec_t tbl[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ctl"}, {24'd0, gnt0, gnt1, done0, done1, err, busy, clean, load}, 32'd0);
        check({name, "_res"}, {16'd0, result}, 32'd0);
        check({name, "_opnd"}, {16'd0, mltnd, mlter}, 32'd0);
        check({name, "_state"}, {29'd0, state}, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; mltd_done = 1'b0; mltr_done = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_last = 1;
    endtask

    // Called at a negedge with the DUT in IDLE; returns at the negedge of the
    // IDLE cycle following RESP (or after the wait budget when no done is expected).
    task automatic do_txn(input string name, input bit r0, input bit r1,
                          input logic [7:0] xa0, input logic [7:0] xb0,
                          input logic [7:0] xa1, input logic [7:0] xb1,
                          input int d_at, input int r_at, input bit hold,
                          input int exp_win, input logic [15:0] exp_res,
                          input int exp_done, input bit exp_err);
        int c, load_c, done_c, done_cnt, budget, k;
        bit both_gnt;
        logic [7:0] ea, eb;
        ea = exp_win ? xa1 : xa0;
        eb = exp_win ? xb1 : xb0;
        req0 = r0; req1 = r1; a0 = xa0; b0 = xb0; a1 = xa1; b1 = xb1;
        c = 0; load_c = -1; done_c = -1; done_cnt = 0; both_gnt = 0;
        budget = (exp_done > 0) ? exp_done + 1 : 100;
        while (c < budget) begin
            @(negedge clk);
            c++;
            if (gnt0 && gnt1) both_gnt = 1;
            if (c == 1) begin
                check({name, "_gnt"}, {30'd0, gnt1, gnt0}, exp_win ? 32'd2 : 32'd1);
                check({name, "_clean"}, {31'd0, clean}, 32'd1);
                check({name, "_opnd"}, {16'd0, mltnd, mlter}, {16'd0, ea, eb});
                if (!hold) begin req0 = 1'b0; req1 = 1'b0; end
                a0 = 8'($urandom); b0 = 8'($urandom); a1 = 8'($urandom); b1 = 8'($urandom);
            end
            if (c == 2) check({name, "_load"}, {31'd0, load}, 32'd1);
            if (exp_done > 0 && c == exp_done - 1)
                check({name, "_opnd_hold"}, {16'd0, mltnd, mlter}, {16'd0, ea, eb});
            if (done0 || done1) begin
                done_cnt++;
                if (done_c < 0) begin
                    done_c = c;
                    check({name, "_done_who"}, {30'd0, done1, done0}, exp_win ? 32'd2 : 32'd1);
                    check({name, "_result"}, {16'd0, result}, {16'd0, exp_res});
                    check({name, "_err"}, {31'd0, err}, {31'd0, exp_err});
                end
            end
            if (exp_done > 0 && c == exp_done + 1)
                check({name, "_idle"}, {29'd0, busy, done0, done1}, 32'd0);
            // Datapath emulation: multiplier output and shift-complete flags.
            if (load) load_c = c;
            k = (load_c > 0) ? c - load_c : 0;
            mltd_done = (k > 0 && k == d_at);
            mltr_done = (k > 0 && k == r_at);
            product = mltnd * mlter;
        end
        mltd_done = 1'b0; mltr_done = 1'b0;
        if (exp_done > 0) begin
            check({name, "_done_at"}, done_c, exp_done);
            check({name, "_done_cnt"}, done_cnt, 1);
            check({name, "_excl_gnt"}, {31'd0, both_gnt}, 32'd0);
            model_last = exp_win;
        end else begin
            check({name, "_no_done"}, done_cnt, 0);
            check({name, "_still_busy"}, {31'd0, busy}, 32'd1);
        end
    endtask

    initial begin
        int win, d, r, dn;
        bit r0, r1, hold;
        logic [7:0] x0, y0, x1, y1;
        logic [15:0] p;

        //      r0 r1  a0     b0     a1     b1    d  r  hold win res       done
        tbl[0] = '{1, 0, 8'd3,   8'd5,   8'd0,  8'd0, 8, 8, 0, 0, 16'd15,    12};
        tbl[1] = '{0, 1, 8'd0,   8'd0,   8'hFE, 8'd7, 3, 3, 0, 1, 16'h06F2,  7};
        tbl[2] = '{1, 0, 8'd12,  8'd11,  8'd0,  8'd0, 2, 9, 0, 0, 16'd132,   13};
        tbl[3] = '{1, 1, 8'd2,   8'd2,   8'd9,  8'd9, 1, 1, 1, 1, 16'd81,    5};
        tbl[4] = '{1, 1, 8'd255, 8'd255, 8'd1,  8'd1, 5, 1, 1, 0, 16'hFE01,  9};
        tbl[5] = '{0, 1, 8'd0,   8'd0,   8'd0,  8'd77, 4, 6, 0, 1, 16'd0,    10};

        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Both requests held high from reset: strict alternation starting at 0.
        for (int i = 0; i < 4; i++)
            do_txn("tie_seq", 1, 1, 8'd4, 8'd6, 8'd7, 8'd3, 2, 3, 1, i % 2,
                   (i % 2) ? 16'd21 : 16'd24, 7, 0);
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++)
            do_txn($sformatf("vec%0d", i), tbl[i].r0, tbl[i].r1, tbl[i].a0, tbl[i].b0,
                   tbl[i].a1, tbl[i].b1, tbl[i].d_at, tbl[i].r_at, tbl[i].hold,
                   tbl[i].exp_win, tbl[i].exp_res, tbl[i].exp_done, 0);

        // Randomized transactions against the round-robin reference model.
        for (int i = 0; i < 30; i++) begin
            r0 = 1'($urandom_range(0, 1));
            r1 = r0 ? 1'($urandom_range(0, 1)) : 1'b1;
            x0 = 8'($urandom); y0 = 8'($urandom); x1 = 8'($urandom); y1 = 8'($urandom);
            d = $urandom_range(1, 6); r = $urandom_range(1, 6);
            hold = 1'($urandom_range(0, 1));
            win = (r0 && r1) ? 1 - model_last : (r1 ? 1 : 0);
            p = win ? 16'(x1) * 16'(y1) : 16'(x0) * 16'(y0);
            dn = 4 + ((d > r) ? d : r);
            do_txn($sformatf("rnd%0d", i), r0, r1, x0, y0, x1, y1, d, r, hold, win, p, dn, 0);
        end
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);

        // Reset in the middle of RUN for requester 1 abandons the transaction.
        begin
            int seen_done1;
            seen_done1 = 0;
            req1 = 1'b1; a1 = 8'd9; b1 = 8'd9;
            for (int i = 0; i < 5; i++) @(negedge clk);
            check("mid_rst_in_run", {29'd0, state}, 32'd3);
            rst = 1'b1; req1 = 1'b0;
            #1;
            check_all_zero("mid_rst");
            @(negedge clk);
            rst = 1'b0;
            model_last = 1;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (done1) seen_done1++;
            end
            check("mid_rst_no_done1", seen_done1, 0);
            do_txn("post_rst_tie", 1, 1, 8'd6, 8'd7, 8'd8, 8'd9, 1, 2, 0, 0, 16'd42, 6, 0);
        end

        // Datapath never reports done.
`ifdef MULT_ARB_TIMEOUT_EN
        do_txn("timeout", 1, 0, 8'd5, 8'd5, 8'd0, 8'd0, 0, 0, 0, 0, 16'd0, 35, 1);
        @(negedge clk);
        check("timeout_err_clear", {31'd0, err}, 32'd0);
`else
        do_txn("no_timeout", 1, 0, 8'd5, 8'd5, 8'd0, 8'd0, 0, 0, 0, 0, 16'd0, 0, 0);
        check("no_timeout_err", {31'd0, err}, 32'd0);
        do_reset();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
